// File: rtl/cursor_nav.sv
// Purpose : maps debounced direction buttons and absolute mouse coordinates to
//           cursor and viewport moves. The board edge either wraps or clamps.
// Latency : a button sampled at edge t is seen as step_req after t and moves the cursor at t+1.
//           A mouse sample captured at edge t moves the cursor at t+1. moved_out follows one edge later.
// Backpr. : none. A large mouse jump drains one cell step per cycle, so no counts are lost.
// Ports   : clk_in/rst_in (sync, active-high); btn_{up,down,left,right}_in (level);
//           mouse_{x,y}_in (12b absolute); cursor_{x,y}_out, view_{x,y}_out (LOG_BOARD_SIZE b);
//           moved_out (pulse one cycle after any cursor register change).

// Typematic engine for one button: a step on press, a second step after
// DELAY_CYCLES, then one step every REPEAT_CYCLES while the button is held.
module cursor_nav_rpt #(
  parameter int unsigned DELAY_CYCLES  = 8,
  parameter int unsigned REPEAT_CYCLES = 4,
  parameter int unsigned CNT_W         = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic step_req_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_t;

  localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             step_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (!btn_in) begin
        // A release ends the hold in every state and produces no step.
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            step_q  <= 1'b1;
            state_q <= S_DELAY;
            cnt_q   <= '0;
          end
          S_DELAY: begin
            if (cnt_q == DelayLast) begin
              step_q  <= 1'b1;
              state_q <= S_REPEAT;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          S_REPEAT: begin
            if (cnt_q == RepeatLast) begin
              step_q <= 1'b1;
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign step_req_out = step_q;

endmodule

module cursor_nav #(
  parameter int unsigned LOG_BOARD_SIZE = 8,
  parameter int unsigned VIEW_SIZE      = 64,
  parameter int unsigned DELAY_CYCLES   = 2**25,
  parameter int unsigned REPEAT_CYCLES  = 2**22,
  parameter int unsigned MOUSE_SENS     = 16,
  parameter bit          WRAP           = 1'b0
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      btn_up_in,
  input  logic                      btn_down_in,
  input  logic                      btn_left_in,
  input  logic                      btn_right_in,
  input  logic [11:0]               mouse_x_in,
  input  logic [11:0]               mouse_y_in,
  output logic [LOG_BOARD_SIZE-1:0] cursor_x_out,
  output logic [LOG_BOARD_SIZE-1:0] cursor_y_out,
  output logic [LOG_BOARD_SIZE-1:0] view_x_out,
  output logic [LOG_BOARD_SIZE-1:0] view_y_out,
  output logic                      moved_out
);

  localparam int unsigned Lw        = LOG_BOARD_SIZE;
  localparam int unsigned Lw1       = LOG_BOARD_SIZE + 1;
  localparam int unsigned BoardSize = 2**LOG_BOARD_SIZE;
  localparam int unsigned MaxCnt    = (DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCnt + 1);

  localparam logic [Lw-1:0]  CursorRst = Lw'(BoardSize / 2);
  localparam logic [Lw-1:0]  ViewRst   = Lw'((BoardSize - VIEW_SIZE) / 2);
  localparam logic [Lw-1:0]  CellMax   = Lw'(BoardSize - 1);
  localparam logic [Lw-1:0]  CellOne   = Lw'(1);
  localparam logic [Lw1-1:0] ViewSz    = Lw1'(VIEW_SIZE);
  localparam logic [12:0]    Sens13    = 13'(MOUSE_SENS);
  localparam logic [11:0]    Sens12    = 12'(MOUSE_SENS);
  // A viewport covering the whole board never scrolls.
  localparam bit             FullView  = (VIEW_SIZE == BoardSize);

  // ---------------------------------------------------------------------------
  // Button repeat engines, index order: up, down, left, right
  // ---------------------------------------------------------------------------
  logic [3:0] btn_vec;
  logic [3:0] step_req;

  assign btn_vec = {btn_right_in, btn_left_in, btn_down_in, btn_up_in};

  for (genvar g = 0; g < 4; g++) begin : g_rpt
    cursor_nav_rpt #(
      .DELAY_CYCLES  (DELAY_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .CNT_W         (CntW)
    ) u_rpt (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .btn_in       (btn_vec[g]),
      .step_req_out (step_req[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Mouse path: one input register, then a per-axis step decision against the
  // last position already converted into cell steps.
  // ---------------------------------------------------------------------------
  logic [11:0] mouse_x_q, mouse_y_q;
  logic [11:0] last_x_q, last_y_q, last_x_d, last_y_d;
  logic [1:0]  mdir_x, mdir_y;   // bit0 = plus step, bit1 = minus step

  function automatic logic [1:0] mouse_dir(input logic [11:0] pos, input logic [11:0] last);
    logic signed [12:0] d;
    d = $signed({1'b0, pos}) - $signed({1'b0, last});
    mouse_dir = 2'b00;
    // Strict comparisons: a difference of exactly one sensitivity is kept as residual.
    if (d > $signed(Sens13)) begin
      mouse_dir = 2'b01;
    end else if (d < -$signed(Sens13)) begin
      mouse_dir = 2'b10;
    end
  endfunction

  always_comb begin
    mdir_x   = mouse_dir(mouse_x_q, last_x_q);
    mdir_y   = mouse_dir(mouse_y_q, last_y_q);
    last_x_d = last_x_q;
    last_y_d = last_y_q;
    // last advances even when the axis move is cancelled by a conflicting button.
    if (mdir_x[0]) begin
      last_x_d = last_x_q + Sens12;
    end else if (mdir_x[1]) begin
      last_x_d = last_x_q - Sens12;
    end
    if (mdir_y[0]) begin
      last_y_d = last_y_q + Sens12;
    end else if (mdir_y[1]) begin
      last_y_d = last_y_q - Sens12;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-axis arbitration and cursor / viewport update
  // ---------------------------------------------------------------------------
  logic plus_x, minus_x, plus_y, minus_y;

  assign plus_x  = step_req[3] | mdir_x[0];
  assign minus_x = step_req[2] | mdir_x[1];
  assign plus_y  = step_req[1] | mdir_y[0];
  assign minus_y = step_req[0] | mdir_y[1];

  // Returns {next_cursor, next_view} for one axis.
  function automatic logic [2*Lw-1:0] axis_next(input logic [Lw-1:0] cur,
                                                input logic [Lw-1:0] view,
                                                input logic          plus,
                                                input logic          minus);
    logic [Lw-1:0] cur_n;
    logic [Lw-1:0] view_n;
    logic [Lw-1:0] off;
    cur_n  = cur;
    view_n = view;
    if (plus && !minus) begin
      if (WRAP || (cur != CellMax)) begin
        cur_n = cur + CellOne;
      end
    end else if (minus && !plus) begin
      if (WRAP || (cur != '0)) begin
        cur_n = cur - CellOne;
      end
    end
    // Offset of the new cursor inside the viewport, modulo the board. Because
    // the cursor only moves by one cell, leaving the window shows up as an
    // offset of exactly VIEW_SIZE (right/down) or all-ones (left/up).
    off = cur_n - view;
    if (!FullView && (cur_n != cur)) begin
      if (plus && ({1'b0, off} == ViewSz)) begin
        view_n = view + CellOne;
      end else if (minus && (off == CellMax)) begin
        view_n = view - CellOne;
      end
    end
    return {cur_n, view_n};
  endfunction

  logic [Lw-1:0] cursor_x_q, cursor_y_q, cursor_x_d, cursor_y_d;
  logic [Lw-1:0] view_x_q, view_y_q, view_x_d, view_y_d;
  logic          chg_q;
  logic          moved_q;

  always_comb begin
    {cursor_x_d, view_x_d} = axis_next(cursor_x_q, view_x_q, plus_x, minus_x);
    {cursor_y_d, view_y_d} = axis_next(cursor_y_q, view_y_q, plus_y, minus_y);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cursor_x_q <= CursorRst;
      cursor_y_q <= CursorRst;
      view_x_q   <= ViewRst;
      view_y_q   <= ViewRst;
      // Seeding last with the live position avoids a jump when reset releases.
      mouse_x_q  <= mouse_x_in;
      mouse_y_q  <= mouse_y_in;
      last_x_q   <= mouse_x_in;
      last_y_q   <= mouse_y_in;
      chg_q      <= 1'b0;
      moved_q    <= 1'b0;
    end else begin
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      view_x_q   <= view_x_d;
      view_y_q   <= view_y_d;
      mouse_x_q  <= mouse_x_in;
      mouse_y_q  <= mouse_y_in;
      last_x_q   <= last_x_d;
      last_y_q   <= last_y_d;
      // chg_q marks the edge the cursor register changed; moved_q is its
      // one-cycle-later copy seen by the renderer.
      chg_q      <= (cursor_x_d != cursor_x_q) || (cursor_y_d != cursor_y_q);
      moved_q    <= chg_q;
    end
  end

  assign cursor_x_out = cursor_x_q;
  assign cursor_y_out = cursor_y_q;
  assign view_x_out   = view_x_q;
  assign view_y_out   = view_y_q;
  assign moved_out    = moved_q;

endmodule

// File: tb/tb_cursor_nav.sv
// Bench for cursor_nav: two instances (clamp and wrap) driven by the same
// directed stimulus, checked every cycle against a behavioural model, plus
// hand-computed literal checkpoints.
module tb_cursor_nav;

  localparam int LOG   = 6;
  localparam int BOARD = 64;
  localparam int VIEW  = 16;
  localparam int DLY   = 8;
  localparam int RPT   = 4;
  localparam int SENS  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn;        // 0 up, 1 down, 2 left, 3 right
  logic [11:0] mouse_x, mouse_y;
  logic [LOG-1:0] cx0, cy0, vx0, vy0, cx1, cy1, vx1, vy1;
  logic        mv0, mv1;

  int n_chk = 0;
  int n_err = 0;
  int mv0_cnt = 0;
  bit win = 1'b0;

  always #5 clk = ~clk;

  cursor_nav #(
    .LOG_BOARD_SIZE(LOG), .VIEW_SIZE(VIEW), .DELAY_CYCLES(DLY),
    .REPEAT_CYCLES(RPT), .MOUSE_SENS(SENS), .WRAP(1'b0)
  ) dut_clamp (
    .clk_in(clk), .rst_in(rst),
    .btn_up_in(btn[0]), .btn_down_in(btn[1]), .btn_left_in(btn[2]), .btn_right_in(btn[3]),
    .mouse_x_in(mouse_x), .mouse_y_in(mouse_y),
    .cursor_x_out(cx0), .cursor_y_out(cy0), .view_x_out(vx0), .view_y_out(vy0),
    .moved_out(mv0)
  );

  cursor_nav #(
    .LOG_BOARD_SIZE(LOG), .VIEW_SIZE(VIEW), .DELAY_CYCLES(DLY),
    .REPEAT_CYCLES(RPT), .MOUSE_SENS(SENS), .WRAP(1'b1)
  ) dut_wrap (
    .clk_in(clk), .rst_in(rst),
    .btn_up_in(btn[0]), .btn_down_in(btn[1]), .btn_left_in(btn[2]), .btn_right_in(btn[3]),
    .mouse_x_in(mouse_x), .mouse_y_in(mouse_y),
    .cursor_x_out(cx1), .cursor_y_out(cy1), .view_x_out(vx1), .view_y_out(vy1),
    .moved_out(mv1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. Buttons are tracked as "samples held so far": a step is
  // due on the first sample, at DLY, and every RPT after that. Positions are
  // plain integers; wrap uses modulo, clamp refuses out-of-board targets.
  // ---------------------------------------------------------------------------
  int m_h [4];
  bit m_breq [4];
  int m_mq [2];
  int m_last [2];
  int m_cur [2][2];    // [wrap][axis]
  int m_view [2][2];
  bit m_chg [2];
  bit m_mv [2];
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int diff, dir, tgt, off;
    bit mp, mm, np, nm;
    bit moved_any [2];
    if (rst) begin
      for (int d = 0; d < 4; d++) begin
        m_h[d]    = -1;
        m_breq[d] = 1'b0;
      end
      m_mq[0]   = int'(mouse_x);
      m_mq[1]   = int'(mouse_y);
      m_last[0] = m_mq[0];
      m_last[1] = m_mq[1];
      for (int w = 0; w < 2; w++) begin
        for (int a = 0; a < 2; a++) begin
          m_cur[w][a]  = BOARD / 2;
          m_view[w][a] = (BOARD - VIEW) / 2;
        end
        m_chg[w] = 1'b0;
        m_mv[w]  = 1'b0;
      end
      m_valid = 1'b1;
    end else begin
      moved_any[0] = 1'b0;
      moved_any[1] = 1'b0;
      for (int a = 0; a < 2; a++) begin
        diff = m_mq[a] - m_last[a];
        mp   = diff > SENS;
        mm   = diff < -SENS;
        np   = ((a == 0) ? m_breq[3] : m_breq[1]) | mp;
        nm   = ((a == 0) ? m_breq[2] : m_breq[0]) | mm;
        if (mp) m_last[a] = m_last[a] + SENS;
        if (mm) m_last[a] = m_last[a] - SENS;
        dir = (np && !nm) ? 1 : ((nm && !np) ? -1 : 0);
        for (int w = 0; w < 2; w++) begin
          if (dir != 0) begin
            tgt = m_cur[w][a] + dir;
            if (w == 1) tgt = (tgt + BOARD) % BOARD;
            if (tgt >= 0 && tgt < BOARD) begin
              m_cur[w][a]  = tgt;
              moved_any[w] = 1'b1;
              off = tgt - m_view[w][a];
              if (w == 1) off = (off + BOARD) % BOARD;
              if (off < 0 || off >= VIEW) begin
                m_view[w][a] = m_view[w][a] + dir;
                if (w == 1) m_view[w][a] = (m_view[w][a] + BOARD) % BOARD;
              end
            end
          end
        end
      end
      for (int w = 0; w < 2; w++) begin
        m_mv[w]  = m_chg[w];
        m_chg[w] = moved_any[w];
      end
      m_mq[0] = int'(mouse_x);
      m_mq[1] = int'(mouse_y);
      for (int d = 0; d < 4; d++) begin
        if (btn[d]) begin
          m_h[d]++;
          m_breq[d] = (m_h[d] == 0) || (m_h[d] == DLY) ||
                      (m_h[d] > DLY && ((m_h[d] - DLY) % RPT) == 0);
        end else begin
          m_h[d]    = -1;
          m_breq[d] = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp_clamp_cursor_x", int'(cx0), m_cur[0][0]);
      chk("cmp_clamp_cursor_y", int'(cy0), m_cur[0][1]);
      chk("cmp_clamp_view_x",   int'(vx0), m_view[0][0]);
      chk("cmp_clamp_view_y",   int'(vy0), m_view[0][1]);
      chk("cmp_clamp_moved",    int'(mv0), int'(m_mv[0]));
      chk("cmp_wrap_cursor_x",  int'(cx1), m_cur[1][0]);
      chk("cmp_wrap_cursor_y",  int'(cy1), m_cur[1][1]);
      chk("cmp_wrap_view_x",    int'(vx1), m_view[1][0]);
      chk("cmp_wrap_view_y",    int'(vy1), m_view[1][1]);
      chk("cmp_wrap_moved",     int'(mv1), int'(m_mv[1]));
      if (win && mv0) mv0_cnt++;
    end
  end

  initial begin
    rst     = 1'b1;
    btn     = '0;
    mouse_x = 12'd1000;
    mouse_y = 12'd1000;
    tick(2);
    rst = 1'b0;
    chk("rst_cursor_x", int'(cx0), 32);
    chk("rst_cursor_y", int'(cy0), 32);
    chk("rst_view_x",   int'(vx0), 24);
    chk("rst_view_y",   int'(vy0), 24);
    chk("rst_moved",    int'(mv0), 0);
    chk("rst_wrap_cx",  int'(cx1), 32);

    // Right held for 20 sampled edges: steps at 0, 8, 12, 16.
    btn[3] = 1'b1;
    tick(1); chk("hold_wait_cx",  int'(cx0), 32);
    tick(1); chk("hold_first_cx", int'(cx0), 33);
             chk("hold_first_mv", int'(mv0), 0);
    tick(1); chk("hold_first_moved", int'(mv0), 1);
    tick(6); chk("hold_delay_cx", int'(cx0), 33);
    tick(1); chk("hold_second_cx", int'(cx0), 34);
    tick(10);
    btn[3] = 1'b0;
    tick(6);
    chk("hold_total_cx", int'(cx0), 36);
    chk("hold_view_x",   int'(vx0), 24);
    chk("model_hold_cx", m_cur[0][0], 36);

    // Single tap then three separated pulses on up.
    btn[0] = 1'b1; tick(1); btn[0] = 1'b0; tick(4);
    chk("tap_up_cy", int'(cy0), 31);
    repeat (3) begin
      btn[0] = 1'b1; tick(1); btn[0] = 1'b0; tick(2);
    end
    tick(4);
    chk("pulses_up_cy", int'(cy0), 28);
    chk("pulses_view_y", int'(vy0), 24);

    // Mouse +50: three steps on consecutive cycles, residual 2 kept.
    mouse_x = 12'd1050;
    tick(1);
    tick(1); chk("mouse_step1_cx", int'(cx0), 37);
    tick(1); chk("mouse_step2_cx", int'(cx0), 38);
    tick(1); chk("mouse_step3_cx", int'(cx0), 39);
    tick(3); chk("mouse_residual_cx", int'(cx0), 39);
    chk("model_mouse_last", m_last[0], 1048);
    // +14: residual equals one sensitivity exactly, still no step.
    mouse_x = 12'd1064; tick(6);
    chk("mouse_exact_sens_cx", int'(cx0), 39);
    // One more count tips it over.
    mouse_x = 12'd1065; tick(6);
    chk("mouse_over_sens_cx", int'(cx0), 40);

    // Left tap against mouse +20 in the same cycle: axis cancels, last advances.
    btn[2] = 1'b1; mouse_x = 12'd1085; tick(1); btn[2] = 1'b0; tick(5);
    chk("conflict_cx", int'(cx0), 40);
    chk("model_conflict_last", m_last[0], 1080);

    // Diagonal: down and right together move both axes on the same edge.
    btn[1] = 1'b1; btn[3] = 1'b1; tick(1); btn[1] = 1'b0; btn[3] = 1'b0;
    tick(1);
    chk("diag_cx", int'(cx0), 41);
    chk("diag_cy", int'(cy0), 29);
    tick(1); chk("diag_moved", int'(mv0), 1);
    tick(4);

    // Drive x to the right edge by mouse: +360 gives 22 steps, 41 -> 63.
    mouse_x = 12'd1440; tick(30);
    chk("edge_clamp_cx", int'(cx0), 63);
    chk("edge_clamp_vx", int'(vx0), 48);
    chk("edge_wrap_cx",  int'(cx1), 63);
    chk("edge_wrap_vx",  int'(vx1), 48);

    // Right held 12 samples (steps at 0 and 8): clamp blocks, wrap goes 63->0->1.
    win = 1'b1;
    btn[3] = 1'b1; tick(12); btn[3] = 1'b0; tick(6);
    win = 1'b0;
    chk("clamp_hold_cx", int'(cx0), 63);
    chk("clamp_hold_vx", int'(vx0), 48);
    chk("clamp_moved_count", mv0_cnt, 0);
    chk("wrap_hold_cx", int'(cx1), 1);
    chk("wrap_hold_vx", int'(vx1), 50);

    // Down held into REPEAT, then reset while still held.
    btn[1] = 1'b1; tick(18);
    chk("pre_reset_cy", int'(cy0), 33);
    rst = 1'b1; tick(2);
    chk("mid_rst_cx",      int'(cx0), 32);
    chk("mid_rst_cy",      int'(cy0), 32);
    chk("mid_rst_vx",      int'(vx0), 24);
    chk("mid_rst_vy",      int'(vy0), 24);
    chk("mid_rst_moved",   int'(mv0), 0);
    chk("mid_rst_wrap_cx", int'(cx1), 32);
    chk("mid_rst_wrap_vx", int'(vx1), 24);
    rst = 1'b0;
    tick(1); chk("post_rst_wait_cy",  int'(cy0), 32);
    tick(1); chk("post_rst_step_cy",  int'(cy0), 33);
    tick(7); chk("post_rst_delay_cy", int'(cy0), 33);
    tick(1); chk("post_rst_second_cy", int'(cy0), 34);
    btn[1] = 1'b0; tick(5);
    chk("post_rst_final_cy", int'(cy0), 34);
    chk("post_rst_no_mouse_jump_cx", int'(cx0), 32);

    tick(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
